// File: rtl/window_gen_pkg.sv
// window_gen_pkg: shared constants, pixel type and counter sizing for the 3x3 window generator.
package window_gen_pkg;
   localparam int PIX_W_DEF = 8;
   // Tap index = column*3 + row, column 0 = x-1, row 0 = y-1.
   localparam int TAP_XM1YM1 = 0;
   localparam int TAP_XM1Y0  = 1;
   localparam int TAP_XM1YP1 = 2;
   localparam int TAP_X0YM1  = 3;
   localparam int TAP_X0Y0   = 4;
   localparam int TAP_X0YP1  = 5;
   localparam int TAP_XP1YM1 = 6;
   localparam int TAP_XP1Y0  = 7;
   localparam int TAP_XP1YP1 = 8;
   typedef logic [PIX_W_DEF-1:0] pixel_t;
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/window_gen_3x3_line_buffer.sv
// line_buffer: DEPTH-deep enable-qualified delay line, RAM with wrapping address, read-before-write.
module line_buffer
   import window_gen_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int W     = PIX_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] dout_o
);
   localparam int AW = cnt_w(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] addr_q, addr_d;
   assign dout_o = mem_q[addr_q];
   always_comb addr_d = !en_i ? addr_q : (addr_q == LAST) ? '0 : addr_q + 1'b1;
   always_ff @(posedge clk) begin
      if (rst) addr_q <= '0;
      else     addr_q <= addr_d;
   end
   always_ff @(posedge clk) begin
      if (en_i) mem_q[addr_q] <= din_i;
   end
endmodule

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster stream to registered 3x3 neighbourhood taps with window-valid/last strobes.
// Optional WINDOW_GEN_SOF_EN adds a sof input that forces the accompanying pixel to position (0,0).
module window_gen_3x3
   import window_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int PIX_W      = PIX_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             pix_valid,
`ifdef WINDOW_GEN_SOF_EN
   input  logic             sof,
`endif
   output logic [PIX_W-1:0] xm1ym1,
   output logic [PIX_W-1:0] xm1y0,
   output logic [PIX_W-1:0] xm1yp1,
   output logic [PIX_W-1:0] x0ym1,
   output logic [PIX_W-1:0] x0y0,
   output logic [PIX_W-1:0] x0yp1,
   output logic [PIX_W-1:0] xp1ym1,
   output logic [PIX_W-1:0] xp1y0,
   output logic [PIX_W-1:0] xp1yp1,
   output logic             win_valid,
   output logic             win_last
);
   localparam int CW = cnt_w(IMG_WIDTH);
   localparam int RW = cnt_w(IMG_HEIGHT);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
   logic [PIX_W-1:0] win_q [9];
   logic [PIX_W-1:0] win_d [9];
   logic [PIX_W-1:0] line_a, line_b;
   logic [CW-1:0]    col_q, col_d, col_c;
   logic [RW-1:0]    row_q, row_d, row_c;
   logic             valid_q, valid_d, last_q, last_d, sof_hit, col_end, row_end;
`ifdef WINDOW_GEN_SOF_EN
   assign sof_hit = pix_valid & sof;
`else
   assign sof_hit = 1'b0;
`endif
   line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_line_a (
      .clk(clk), .rst(rst), .en_i(pix_valid), .din_i(pix_in), .dout_o(line_a)
   );
   line_buffer #(.DEPTH(IMG_WIDTH), .W(PIX_W)) u_line_b (
      .clk(clk), .rst(rst), .en_i(pix_valid), .din_i(line_a), .dout_o(line_b)
   );
   // col_c/row_c are the position of the pixel being accepted this cycle.
   always_comb begin
      col_c   = sof_hit ? '0 : col_q;
      row_c   = sof_hit ? '0 : row_q;
      col_end = col_c == COL_LAST;
      row_end = row_c == ROW_LAST;
      col_d   = !pix_valid ? col_q : col_end ? '0 : col_c + 1'b1;
      row_d   = !pix_valid ? row_q : !col_end ? row_c : row_end ? '0 : row_c + 1'b1;
      valid_d = pix_valid && col_c >= CW'(2) && row_c >= RW'(2);
      last_d  = valid_d && col_end && row_end;
      win_d   = win_q;
      if (pix_valid) begin
         for (int i = 0; i < 6; i++) win_d[i] = win_q[i+3];
         win_d[TAP_XP1YM1] = line_b;
         win_d[TAP_XP1Y0]  = line_a;
         win_d[TAP_XP1YP1] = pix_in;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q   <= '{default: '0};
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         win_q   <= win_d;
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         last_q  <= last_d;
      end
   end
   assign xm1ym1    = win_q[TAP_XM1YM1];
   assign xm1y0     = win_q[TAP_XM1Y0];
   assign xm1yp1    = win_q[TAP_XM1YP1];
   assign x0ym1     = win_q[TAP_X0YM1];
   assign x0y0      = win_q[TAP_X0Y0];
   assign x0yp1     = win_q[TAP_X0YP1];
   assign xp1ym1    = win_q[TAP_XP1YM1];
   assign xp1y0     = win_q[TAP_XP1Y0];
   assign xp1yp1    = win_q[TAP_XP1YP1];
   assign win_valid = valid_q;
   assign win_last  = last_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed/random frames on a 5x4 image, checked against a pixel-history model.
module tb_window_gen_3x3;
   import window_gen_pkg::*;
   localparam int W = 5;
   localparam int H = 4;
   logic clk = 1'b0, rst = 1'b0, pix_valid = 1'b0;
   pixel_t pix_in = '0;
`ifdef WINDOW_GEN_SOF_EN
   logic sof = 1'b0;
`endif
   pixel_t xm1ym1, xm1y0, xm1yp1, x0ym1, x0y0, x0yp1, xp1ym1, xp1y0, xp1yp1;
   logic win_valid, win_last;
   logic [8:0][7:0] taps_all;
   int checks = 0, failures = 0;
   pixel_t hist[$];
   int mark = 0, nsr = 0, pc = 0, pr = 0, wins = 0;
   bit pat = 1'b0;

   always #5 clk = ~clk;

   window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
      .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid),
`ifdef WINDOW_GEN_SOF_EN
      .sof(sof),
`endif
      .xm1ym1(xm1ym1), .xm1y0(xm1y0), .xm1yp1(xm1yp1),
      .x0ym1(x0ym1), .x0y0(x0y0), .x0yp1(x0yp1),
      .xp1ym1(xp1ym1), .xp1y0(xp1y0), .xp1yp1(xp1yp1),
      .win_valid(win_valid), .win_last(win_last)
   );
   assign taps_all = {xp1yp1, xp1y0, xp1ym1, x0yp1, x0y0, x0ym1, xm1yp1, xm1y0, xm1ym1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // A tap at column age a / row age ra is the pixel accepted a + W*ra acceptances ago,
   // or still zero if fewer than a+1 pixels have arrived since reset.
   task automatic check_taps();
      for (int cp = 0; cp < 3; cp++)
         for (int rp = 0; rp < 3; rp++) begin
            int a, ra, idx;
            a = 2 - cp;
            ra = 2 - rp;
            idx = hist.size() - 1 - a - W * ra;
            if (a >= nsr) chk($sformatf("tap%0d_zero", cp*3+rp), 32'(taps_all[cp*3+rp]), 32'h0);
            else if (idx >= mark) chk($sformatf("tap%0d", cp*3+rp), 32'(taps_all[cp*3+rp]), 32'(hist[idx]));
         end
   endtask

   task automatic step(input bit v, input bit s, input pixel_t p);
      int c, r;
      bit ev, el;
      @(negedge clk);
      rst = 1'b0;
      pix_valid = v;
      pix_in = p;
`ifdef WINDOW_GEN_SOF_EN
      sof = s;
`endif
      c = s ? 0 : pc;
      r = s ? 0 : pr;
      ev = v && c >= 2 && r >= 2;
      el = ev && c == W - 1 && r == H - 1;
      if (v) begin
         hist.push_back(p);
         nsr++;
         pc = c + 1;
         pr = r;
         if (pc == W) begin
            pc = 0;
            pr = (r + 1) % H;
         end
      end
      @(posedge clk);
      #1;
      chk("win_valid", 32'(win_valid), 32'(ev));
      chk("win_last", 32'(win_last), 32'(el));
      check_taps();
      if (win_valid === 1'b1) wins++;
      if (pat && ev && c == 2 && r == 2) begin
         chk("first_xp1yp1", 32'(xp1yp1), 32'h22);
         chk("first_x0y0", 32'(x0y0), 32'h11);
         chk("first_xm1ym1", 32'(xm1ym1), 32'h00);
         chk("first_xp1ym1", 32'(xp1ym1), 32'h02);
         chk("first_xm1yp1", 32'(xm1yp1), 32'h20);
      end
      if (pat && el) begin
         chk("last_xp1yp1", 32'(xp1yp1), 32'h34);
         chk("last_x0y0", 32'(x0y0), 32'h23);
         chk("last_xm1ym1", 32'(xm1ym1), 32'h12);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      pix_valid = 1'b0;
`ifdef WINDOW_GEN_SOF_EN
      sof = 1'b0;
`endif
      @(posedge clk);
      #1;
      chk("rst_win_valid", 32'(win_valid), 32'h0);
      chk("rst_win_last", 32'(win_last), 32'h0);
      chk("rst_taps", 32'(|taps_all), 32'h0);
      pc = 0;
      pr = 0;
      nsr = 0;
      mark = hist.size();
      rst = 1'b0;
   endtask

   task automatic frame(input bit pattern, input bit gaps, input bit sof_first);
      pat = pattern;
      wins = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            while (gaps && $urandom_range(1, 0) == 1) step(1'b0, 1'b0, pixel_t'($urandom));
            step(1'b1, sof_first && r == 0 && c == 0,
                 pattern ? pixel_t'(r * 16 + c) : pixel_t'($urandom));
         end
      chk("win_count", 32'(wins), 32'd6);
      pat = 1'b0;
   endtask

   initial begin
      do_reset();
      do_reset();
      frame(1'b1, 1'b0, 1'b0);
      frame(1'b1, 1'b1, 1'b0);
      frame(1'b0, 1'b0, 1'b0);
      frame(1'b0, 1'b1, 1'b0);
      frame(1'b1, 1'b0, 1'b0);
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < ((r == 1) ? 4 : W); c++) step(1'b1, 1'b0, pixel_t'(r * 16 + c));
      do_reset();
      frame(1'b1, 1'b0, 1'b0);
`ifdef WINDOW_GEN_SOF_EN
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < ((r == 2) ? 2 : W); c++) step(1'b1, 1'b0, pixel_t'($urandom));
      frame(1'b1, 1'b0, 1'b1);
      frame(1'b0, 1'b1, 1'b0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
